fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch controller for the 16-bit processor: it reads the current PC value, issues one read per instruction to the synchronous instruction memory, and captures the returned word into the instruction register (IR). It then presents the IR to the control-unit decoder with a valid/ack handshake and pulses the PC increment enable once per completed fetch. It drives the `inc` input of the PC register (R7). Branch writes into the PC use that register's `Rin` and are signalled to this block via `Redirect`, which kills any in-flight fetch.

## Interface
- `n`, 16: data/address width.
- `MEM_LATENCY`, 1: cycles from the address-sampling edge to valid `Mem_DIN`; legal range 1..3.

- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Run`  in  1  fetch enable; sampled in IDLE and at handshake completion.
- `PC`  in  n  current PC value (PC register output).
- `Mem_DIN`  in  n  instruction memory read data.
- `IR_ack`  in  1  decoder has consumed `IR`.
- `Redirect`  in  1  branch written into PC this cycle; abort the current fetch.
- `Mem_ADDR`  out  n  instruction memory address.
- `Mem_RD`  out  1  read strobe, one cycle per fetch.
- `pc_inc`  out  1  PC increment enable, one-cycle pulse.
- `IR`  out  n  instruction register.
- `IR_valid`  out  1  `IR` holds an unconsumed instruction.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- Reset values:
  - state = IDLE
  - `IR` = 0
  - `IR_valid` = 0
  - `Mem_RD` = 0
  - `pc_inc` = 0
  - address latch = 0, so `Mem_ADDR` = 0
  - latency counter = 0
  - `Busy` = 0
- **IDLE**: if `Run` is high, go to REQ.
- **REQ** (exactly one cycle):
  - `Mem_RD` = 1 and `Mem_ADDR` = `PC` (combinational pass-through).
  - Address latch loads `PC`; latency counter loads `MEM_LATENCY`; go to WAIT.
- **WAIT**:
  - `Mem_ADDR` = address latch; the counter decrements each cycle.
  - In the cycle where the counter equals 1:
    - `pc_inc` = 1.
    - At the closing edge, `IR` is loaded from `Mem_DIN`, `IR_valid` is set, and the state goes to HOLD.
- **HOLD**:
  - `IR` and `IR_valid` are stable.
  - On `IR_ack`, clear `IR_valid`; go to REQ if `Run` is high, else go to IDLE.
- `Run` low during REQ or WAIT does not abort; the fetch completes, and the block goes to IDLE after the ack.
- `Redirect` in WAIT:
  - No capture, and `pc_inc` is forced to 0, even in the last WAIT cycle.
  - Next state is REQ regardless of `Run`, so the new PC is fetched.
- `Redirect` in HOLD: clear `IR_valid` and go to REQ. `Redirect` wins over a simultaneous `IR_ack`.
- `Redirect` in IDLE or REQ is ignored; the REQ read is already using the new PC through the pass-through.
- `IR_ack` is ignored outside HOLD.
- Address arithmetic is none: the block never adds to the PC. Wrap-around of the PC is the PC register's concern.
- `Reset` asserted mid-fetch: immediate return to reset values, and the in-flight memory data is discarded.

## Timing
- Fetch with `MEM_LATENCY` = L and a same-cycle ack takes L+2 cycles per instruction:
  - REQ at cycle T
  - WAIT at T+1..T+L
  - HOLD from T+L+1
  - next REQ at T+L+2
- `pc_inc` rises in cycle T+L. The PC increments at the same edge that loads `IR`, so the next REQ sees `PC`+1.
- `IR_valid` rises at cycle T+L+1 and falls the cycle after `IR_ack` is sampled high.
- `Mem_RD` is high only in REQ and is never asserted in two consecutive cycles.
- `Busy` is combinational from the state; all other outputs except `Mem_ADDR` and `pc_inc` are registered.

## Structure
- Shared header `fetch_defs.vh` holds:
  - state encodings `S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD` (2-bit);
  - `PC_RESET` = 16'h0080;
  - `MEM_LATENCY_MAX` = 3.
- One sub-module, `fetch_lat_cnt`: a 2-bit down-counter with load, decrement and an `is_one` flag.
- The FSM, the `IR` and the address latch live in `fetch_unit`.

## Test plan
- **Reset**: assert `Reset` mid-WAIT.
  - Required: all outputs at reset values without a clock edge; after release with `Run` = 0, the block stays in IDLE.
- **Basic fetch, L=1**: `PC` = 16'h0080, memory[0x80] = 16'h1234, `Run` = 1, `IR_ack` tied high.
  - `Mem_RD` high at T.
  - `pc_inc` high at T+1.
  - `IR` = 16'h1234 with `IR_valid` at T+2.
  - Next `Mem_RD` at T+3 with `Mem_ADDR` = 16'h0081.
- **Latency 3**: same stimulus with L=3.
  - `pc_inc` at T+3; `IR` valid at T+4; exactly one `pc_inc` per fetch.
- **Backpressure**: hold `IR_ack` low for 5 cycles in HOLD.
  - `IR` and `IR_valid` stable; no `Mem_RD`, no `pc_inc`.
  - After the ack, the next REQ follows in the next cycle.
- **Redirect in last WAIT cycle**: `PC` changes to 16'h0040 with `Redirect`.
  - No `IR` load and no `pc_inc`.
  - REQ next cycle with `Mem_ADDR` = 16'h0040.
- **Redirect with `IR_ack` in HOLD**, then `Run` dropped mid-WAIT:
  - `IR_valid` clears and the block refetches.
  - The fetch completes, then goes to IDLE after the ack; `Busy` falls.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding,
// the PC reset vector and the deepest memory latency the counter supports.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [15:0] PC_RESET        = 16'h0080;
  localparam int          MEM_LATENCY_MAX = 3;

endpackage

// File: rtl/fetch_unit_lat_cnt.sv
// Two-bit memory latency down-counter; isOne marks the cycle in which the
// instruction memory data is valid and may be captured.
module fetch_lat_cnt
  import fetch_unit_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [1:0] i_loadValue,
  input  logic       i_dec,
  output logic       o_isOne
);

  logic [1:0] r_count;

  // Load has priority; decrement saturates at zero so an idle counter stays put.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != 2'd0)) begin
      r_count <= r_count - 2'd1;
    end
  end

  assign o_isOne = (r_count == 2'd1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: issues one memory read per instruction, captures
// the returned word into IR and hands it to the decoder with a valid/ack handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int n           = 16,
  parameter int MEM_LATENCY = 1
)
(
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [n-1:0] PC,
  input  logic [n-1:0] Mem_DIN,
  input  logic         IR_ack,
  input  logic         Redirect,
  output logic [n-1:0] Mem_ADDR,
  output logic         Mem_RD,
  output logic         pc_inc,
  output logic [n-1:0] IR,
  output logic         IR_valid,
  output logic         Busy
);

  localparam logic [1:0] LAT_LOAD = MEM_LATENCY[1:0];

  fetch_state_e r_state;
  fetch_state_e w_nextState;
  logic [n-1:0] r_addrLatch;
  logic [n-1:0] r_ir;
  logic         r_irValid;
  logic         r_memRd;
  logic         w_isOne;
  logic         w_capture;

  fetch_lat_cnt u_latCnt (
    .i_clock     (Clock),
    .i_reset     (Reset),
    .i_load      (r_state == S_REQ),
    .i_loadValue (LAT_LOAD),
    .i_dec       (r_state == S_WAIT),
    .o_isOne     (w_isOne)
  );

  // A redirect kills the in-flight fetch, so it suppresses both capture and pc_inc.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Run) w_nextState = S_REQ;
      end
      S_REQ: begin
        w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (Redirect) begin
          w_nextState = S_REQ;
        end else if (w_isOne) begin
          w_capture   = 1'b1;
          w_nextState = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          w_nextState = S_REQ;
        end else if (IR_ack) begin
          w_nextState = Run ? S_REQ : S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_addrLatch <= '0;
      r_ir        <= '0;
      r_irValid   <= 1'b0;
      r_memRd     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_memRd <= (w_nextState == S_REQ);
      if (r_state == S_REQ) r_addrLatch <= PC;
      if (w_capture) begin
        r_ir      <= Mem_DIN;
        r_irValid <= 1'b1;
      end else if ((r_state == S_HOLD) && (IR_ack || Redirect)) begin
        r_irValid <= 1'b0;
      end
    end
  end

  // In REQ the address passes straight through so a same-cycle PC write is honoured.
  assign Mem_ADDR = (r_state == S_REQ) ? PC : r_addrLatch;
  assign Mem_RD   = r_memRd;
  assign pc_inc   = w_capture;
  assign IR       = r_ir;
  assign IR_valid = r_irValid;
  assign Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at latency 1 and one at latency 3,
// each with a behavioural PC register and synchronous instruction memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  int          checks   = 0;
  int          failures = 0;
  int          incCount3 = 0;

  logic        run1, ack1, redirect1;
  logic [15:0] target1, pc1, memDin1, memAddr1, ir1, lastAddr1;
  logic        memRd1, pcInc1, irValid1, busy1;

  logic        run3, ack3;
  logic [15:0] pc3, memDin3, memAddr3, ir3, lastAddr3;
  logic        memRd3, pcInc3, irValid3, busy3;

  always #5 Clock = ~Clock;

  fetch_unit #(.n(16), .MEM_LATENCY(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Run(run1), .PC(pc1), .Mem_DIN(memDin1),
    .IR_ack(ack1), .Redirect(redirect1), .Mem_ADDR(memAddr1), .Mem_RD(memRd1),
    .pc_inc(pcInc1), .IR(ir1), .IR_valid(irValid1), .Busy(busy1)
  );

  fetch_unit #(.n(16), .MEM_LATENCY(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .Run(run3), .PC(pc3), .Mem_DIN(memDin3),
    .IR_ack(ack3), .Redirect(1'b0), .Mem_ADDR(memAddr3), .Mem_RD(memRd3),
    .pc_inc(pcInc3), .IR(ir3), .IR_valid(irValid3), .Busy(busy3)
  );

  // Memory contents: 0x80 holds 0x1234, every other word is address ^ 0xA5A5.
  function automatic logic [15:0] memWord(input logic [15:0] addr);
    return (addr == 16'h0080) ? 16'h1234 : (addr ^ 16'hA5A5);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc1       <= PC_RESET;
      pc3       <= PC_RESET;
      lastAddr1 <= 16'h0000;
      lastAddr3 <= 16'h0000;
    end else begin
      if (redirect1) pc1 <= target1;
      else if (pcInc1) pc1 <= pc1 + 16'd1;
      if (pcInc3) pc3 <= pc3 + 16'd1;
      if (memRd1) lastAddr1 <= memAddr1;
      if (memRd3) lastAddr3 <= memAddr3;
    end
  end

  always @(posedge Clock) begin
    if (pcInc3) incCount3 <= incCount3 + 1;
  end

  assign memDin1 = memWord(lastAddr1);
  assign memDin3 = memWord(lastAddr3);

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1; run1 = 1'b0; ack1 = 1'b0; redirect1 = 1'b0; target1 = 16'h0000;
    run3 = 1'b0; ack3 = 1'b0;
    nextCycle(); nextCycle();
    Reset = 1'b0; #2;
    checkOutput("rst_ir",      ir1, 16'h0000);
    checkOutput("rst_valid",   16'(irValid1), 16'h0);
    checkOutput("rst_rd",      16'(memRd1), 16'h0);
    checkOutput("rst_pcinc",   16'(pcInc1), 16'h0);
    checkOutput("rst_addr",    memAddr1, 16'h0000);
    checkOutput("rst_busy",    16'(busy1), 16'h0);
    nextCycle(); #2;
    checkOutput("idle_norun_busy", 16'(busy1), 16'h0);

    // Basic fetch at latency 1 with ack tied high
    nextCycle(); run1 = 1'b1; ack1 = 1'b1; #2;
    checkOutput("l1_idle_busy", 16'(busy1), 16'h0);
    nextCycle(); #2;
    checkOutput("l1_T_rd",      16'(memRd1), 16'h1);
    checkOutput("l1_T_addr",    memAddr1, 16'h0080);
    checkOutput("l1_T_busy",    16'(busy1), 16'h1);
    checkOutput("l1_T_pcinc",   16'(pcInc1), 16'h0);
    nextCycle(); #2;
    checkOutput("l1_T1_pcinc",  16'(pcInc1), 16'h1);
    checkOutput("l1_T1_rd",     16'(memRd1), 16'h0);
    checkOutput("l1_T1_valid",  16'(irValid1), 16'h0);
    nextCycle(); #2;
    checkOutput("l1_T2_ir",     ir1, 16'h1234);
    checkOutput("l1_T2_valid",  16'(irValid1), 16'h1);
    checkOutput("l1_T2_pcinc",  16'(pcInc1), 16'h0);
    nextCycle(); ack1 = 1'b0; #2;
    checkOutput("l1_T3_rd",     16'(memRd1), 16'h1);
    checkOutput("l1_T3_addr",   memAddr1, 16'h0081);
    checkOutput("l1_T3_valid",  16'(irValid1), 16'h0);
    nextCycle(); #2;
    checkOutput("l1_T4_pcinc",  16'(pcInc1), 16'h1);

    // Backpressure: ack low for five HOLD cycles
    for (int i = 0; i < 5; i++) begin
      nextCycle(); #2;
      checkOutput("bp_ir",    ir1, 16'hA524);
      checkOutput("bp_valid", 16'(irValid1), 16'h1);
      checkOutput("bp_rd",    16'(memRd1), 16'h0);
      checkOutput("bp_pcinc", 16'(pcInc1), 16'h0);
    end
    nextCycle(); ack1 = 1'b1; #2;
    checkOutput("bp_ack_valid", 16'(irValid1), 16'h1);
    nextCycle(); #2;
    checkOutput("bp_next_rd",    16'(memRd1), 16'h1);
    checkOutput("bp_next_addr",  memAddr1, 16'h0082);
    checkOutput("bp_next_valid", 16'(irValid1), 16'h0);

    // Redirect in the last WAIT cycle
    nextCycle(); redirect1 = 1'b1; target1 = 16'h0040; #2;
    checkOutput("rdw_pcinc", 16'(pcInc1), 16'h0);
    checkOutput("rdw_rd",    16'(memRd1), 16'h0);
    nextCycle(); redirect1 = 1'b0; #2;
    checkOutput("rdw_req_rd",    16'(memRd1), 16'h1);
    checkOutput("rdw_req_addr",  memAddr1, 16'h0040);
    checkOutput("rdw_no_load",   ir1, 16'hA524);
    checkOutput("rdw_req_valid", 16'(irValid1), 16'h0);
    nextCycle(); #2;
    checkOutput("rdw_wait_pcinc", 16'(pcInc1), 16'h1);

    // Redirect with simultaneous ack in HOLD while Run is low
    nextCycle(); redirect1 = 1'b1; target1 = 16'h0050; run1 = 1'b0; #2;
    checkOutput("rdh_ir",    ir1, 16'hA5E5);
    checkOutput("rdh_valid", 16'(irValid1), 16'h1);
    nextCycle(); redirect1 = 1'b0; #2;
    checkOutput("rdh_req_rd",    16'(memRd1), 16'h1);
    checkOutput("rdh_req_addr",  memAddr1, 16'h0050);
    checkOutput("rdh_req_valid", 16'(irValid1), 16'h0);
    nextCycle(); #2;
    checkOutput("rdh_wait_pcinc", 16'(pcInc1), 16'h1);
    checkOutput("rdh_wait_busy",  16'(busy1), 16'h1);
    nextCycle(); #2;
    checkOutput("rdh_hold_ir",    ir1, 16'hA5F5);
    checkOutput("rdh_hold_valid", 16'(irValid1), 16'h1);
    nextCycle(); #2;
    checkOutput("stop_busy",  16'(busy1), 16'h0);
    checkOutput("stop_valid", 16'(irValid1), 16'h0);
    checkOutput("stop_rd",    16'(memRd1), 16'h0);
    checkOutput("stop_ir",    ir1, 16'hA5F5);
    nextCycle(); #2;
    checkOutput("stop2_rd",   16'(memRd1), 16'h0);

    // Latency 3 fetch
    nextCycle(); run3 = 1'b1; ack3 = 1'b1; #2;
    nextCycle(); #2;
    checkOutput("l3_T_rd",      16'(memRd3), 16'h1);
    checkOutput("l3_T_addr",    memAddr3, 16'h0080);
    nextCycle(); #2;
    checkOutput("l3_T1_pcinc",  16'(pcInc3), 16'h0);
    checkOutput("l3_T1_rd",     16'(memRd3), 16'h0);
    nextCycle(); #2;
    checkOutput("l3_T2_pcinc",  16'(pcInc3), 16'h0);
    nextCycle(); #2;
    checkOutput("l3_T3_pcinc",  16'(pcInc3), 16'h1);
    checkOutput("l3_T3_valid",  16'(irValid3), 16'h0);
    nextCycle(); #2;
    checkOutput("l3_T4_ir",     ir3, 16'h1234);
    checkOutput("l3_T4_valid",  16'(irValid3), 16'h1);
    checkOutput("l3_T4_pcinc",  16'(pcInc3), 16'h0);
    nextCycle(); #2;
    checkOutput("l3_T5_rd",     16'(memRd3), 16'h1);
    checkOutput("l3_T5_addr",   memAddr3, 16'h0081);
    checkOutput("l3_inc_count", 16'(incCount3), 16'd1);
    nextCycle(); #2;
    nextCycle(); #2;
    checkOutput("l3_wait_busy", 16'(busy3), 16'h1);

    // Asynchronous reset in the middle of a latency-3 WAIT
    Reset = 1'b1; #1;
    checkOutput("arst_ir",    ir3, 16'h0000);
    checkOutput("arst_valid", 16'(irValid3), 16'h0);
    checkOutput("arst_rd",    16'(memRd3), 16'h0);
    checkOutput("arst_pcinc", 16'(pcInc3), 16'h0);
    checkOutput("arst_addr",  memAddr3, 16'h0000);
    checkOutput("arst_busy",  16'(busy3), 16'h0);
    checkOutput("arst_ir1",   ir1, 16'h0000);
    nextCycle(); Reset = 1'b0; run3 = 1'b0; #2;
    checkOutput("post_busy", 16'(busy3), 16'h0);
    nextCycle(); nextCycle(); #2;
    checkOutput("post_busy2", 16'(busy3), 16'h0);
    checkOutput("post_rd",    16'(memRd3), 16'h0);
    checkOutput("post_ir",    ir3, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
